// File: rtl/keypad_scan_ctrl_if.sv
// Signal bundle between the keypad scanner and its bus wrapper / pad side.
// The master drives scan control, column pads and FIFO strobes. The slave is the scanner.
interface keypad_scan_ctrl_if;
    logic        scan_en;
    logic [15:0] settle_cycles;
    logic [3:0]  col;
    logic [3:0]  row;
    logic        irq_en;
    logic        evt_pop;
    logic        ovf_clr;
    logic [4:0]  evt_data;
    logic        evt_valid;
    logic [4:0]  evt_count;
    logic        overflow;
    logic [15:0] key_state;
    logic        key_irq;

    modport master (
        output scan_en, settle_cycles, col, irq_en, evt_pop, ovf_clr,
        input  row, evt_data, evt_valid, evt_count, overflow, key_state, key_irq
    );

    modport slave (
        input  scan_en, settle_cycles, col, irq_en, evt_pop, ovf_clr,
        output row, evt_data, evt_valid, evt_count, overflow, key_state, key_irq
    );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: the row sequencer, per-key frame debounce and the press/release event FIFO.
// Each frame drives rows 0..3, then spends 16 COMMIT cycles debouncing one key per cycle.
module keypad_scan_ctrl #(
    parameter int DEB_SCANS  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            HCLK,
    input  logic            HRESET,
    keypad_scan_ctrl_if.slave kp
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, COMMIT} state_t;

    state_t      state;
    logic [1:0]  r;
    logic [3:0]  k;
    logic [15:0] settle_cnt;
    logic [15:0] settle_load;
    logic [3:0]  row;
    logic [15:0] raw;
    logic [15:0] stable;
    logic [2:0]  deb_cnt [16];

    logic        deb_diff;
    logic [3:0]  deb_next;
    logic        deb_hit;
    logic        push;
    logic [4:0]  push_data;

    logic [4:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [4:0]    count;
    logic          overflow;
    logic          key_irq;
    logic          full;
    logic          pop_ok;
    logic          wr_ok;

    assign settle_load = (kp.settle_cycles == 16'd0) ? 16'd1 : kp.settle_cycles;

    // Debounce decision for the key currently being committed.
    always_comb begin
        deb_diff  = raw[k] ^ stable[k];
        deb_next  = {1'b0, deb_cnt[k]} + 4'd1;
        deb_hit   = deb_diff && (deb_next == 4'(DEB_SCANS));
        push      = (state == COMMIT) && deb_hit;
        push_data = {~raw[k], k};
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= IDLE;
            row        <= 4'hF;
            r          <= 2'd0;
            k          <= 4'd0;
            settle_cnt <= 16'd0;
            raw        <= 16'd0;
            stable     <= 16'd0;
            for (int i = 0; i < 16; i++) deb_cnt[i] <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (kp.scan_en) begin
                        state      <= DRIVE;
                        r          <= 2'd0;
                        row        <= 4'hE;
                        settle_cnt <= settle_load;
                    end
                end
                DRIVE: begin
                    if (settle_cnt == 16'd1) state <= SAMPLE;
                    else                     settle_cnt <= settle_cnt - 16'd1;
                end
                SAMPLE: begin
                    raw[{r, 2'b00} +: 4] <= ~kp.col;
                    if (r != 2'd3) begin
                        r          <= r + 2'd1;
                        row        <= ~(4'b0001 << (r + 2'd1));
                        settle_cnt <= settle_load;
                        state      <= DRIVE;
                    end else begin
                        k     <= 4'd0;
                        row   <= 4'hF;
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    if (!deb_diff) begin
                        deb_cnt[k] <= 3'd0;
                    end else if (deb_hit) begin
                        stable[k]  <= raw[k];
                        deb_cnt[k] <= 3'd0;
                    end else begin
                        deb_cnt[k] <= deb_next[2:0];
                    end
                    k <= k + 4'd1;
                    // scan_en is only honoured once the whole frame has been committed.
                    if (k == 4'd15) begin
                        if (kp.scan_en) begin
                            state      <= DRIVE;
                            r          <= 2'd0;
                            row        <= 4'hE;
                            settle_cnt <= settle_load;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign full   = (count == 5'(FIFO_DEPTH));
    assign pop_ok = kp.evt_pop && (count != 5'd0);
    assign wr_ok  = push && (!full || pop_ok);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= 5'd0;
            overflow <= 1'b0;
            key_irq  <= 1'b0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, pop_ok})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (push && full && !pop_ok) overflow <= 1'b1;
            else if (kp.ovf_clr)         overflow <= 1'b0;
            key_irq <= (count != 5'd0) && kp.irq_en;
        end
    end

    assign kp.row       = row;
    assign kp.evt_valid = (count != 5'd0);
    assign kp.evt_data  = (count != 5'd0) ? mem[rd_ptr] : 5'd0;
    assign kp.evt_count = count;
    assign kp.overflow  = overflow;
    assign kp.key_state = stable;
    assign kp.key_irq   = key_irq;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: a keypad matrix model plus cycle-exact checks against hand-derived times.
// Cycle n below means "1 time unit after the n-th rising edge since scanning was enabled".
module tb_keypad_scan_ctrl;
    logic        HCLK;
    logic        HRESET;
    logic [15:0] keys;
    int          cyc;
    int          checks;
    int          failures;

    keypad_scan_ctrl_if kp();

    keypad_scan_ctrl #(.DEB_SCANS(4), .FIFO_DEPTH(4)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .kp     (kp)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Matrix model: a held key shorts its column low while its row is driven.
    always_comb begin
        kp.col = 4'hF;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                if (!kp.row[rr] && keys[rr*4+cc]) kp.col[cc] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        HRESET = 1'b1; keys = 16'h0000;
        kp.scan_en = 1'b0; kp.settle_cycles = 16'd1; kp.irq_en = 1'b1;
        kp.evt_pop = 1'b0; kp.ovf_clr = 1'b0;
        tick(); tick();
        chk("rst_row", kp.row, 4'hF);
        chk("rst_count", kp.evt_count, 5'd0);
        chk("rst_valid", kp.evt_valid, 1'b0);
        chk("rst_data", kp.evt_data, 5'd0);
        chk("rst_ovf", kp.overflow, 1'b0);
        chk("rst_keys", kp.key_state, 16'h0000);
        chk("rst_irq", kp.key_irq, 1'b0);

        // Single press of key 9 (row 2, col 1); 24-cycle frames.
        HRESET = 1'b0; keys = 16'h0200; kp.scan_en = 1'b1; cyc = 0;
        run_to(1);  chk("row_r0", kp.row, 4'hE);
        run_to(5);  chk("row_r2", kp.row, 4'hB);
        run_to(9);  chk("row_commit", kp.row, 4'hF);
        run_to(90); chk("press_early", kp.evt_valid, 1'b0);
        run_to(91);
        chk("press_valid", kp.evt_valid, 1'b1);
        chk("press_data", kp.evt_data, 5'h09);
        chk("press_keys", kp.key_state, 16'h0200);
        chk("press_count", kp.evt_count, 5'd1);
        run_to(92); chk("press_irq", kp.key_irq, 1'b1);
        kp.evt_pop = 1'b1;
        run_to(93); kp.evt_pop = 1'b0;
        chk("pop_count", kp.evt_count, 5'd0);
        chk("pop_valid", kp.evt_valid, 1'b0);
        run_to(94); chk("irq_drop", kp.key_irq, 1'b0);

        // Release key 9: frames 5..8, flip at frame 8 COMMIT k=9.
        keys = 16'h0000;
        run_to(186); chk("rel_early", kp.evt_valid, 1'b0);
        run_to(187);
        chk("rel_data", kp.evt_data, 5'h19);
        chk("rel_keys", kp.key_state, 16'h0000);
        kp.evt_pop = 1'b1;
        run_to(188); kp.evt_pop = 1'b0;

        // Bounce: 3 pressed frames, 1 released, then 4 pressed.
        run_to(192); keys = 16'h0200;
        run_to(264); keys = 16'h0000;
        run_to(288); keys = 16'h0200;
        run_to(378); chk("bounce_none", kp.evt_count, 5'd0);
        run_to(379);
        chk("bounce_count", kp.evt_count, 5'd1);
        chk("bounce_data", kp.evt_data, 5'h09);
        kp.evt_pop = 1'b1;
        run_to(380); kp.evt_pop = 1'b0;

        // Overflow: keys 0..4 flip in frame 20 at edges 466..470.
        run_to(384); keys = 16'h021F;
        run_to(469);
        chk("ovf_pre_count", kp.evt_count, 5'd4);
        chk("ovf_pre_flag", kp.overflow, 1'b0);
        run_to(470);
        chk("ovf_count", kp.evt_count, 5'd4);
        chk("ovf_flag", kp.overflow, 1'b1);
        chk("ovf_head", kp.evt_data, 5'h00);
        kp.evt_pop = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("ovf_order", kp.evt_data, 5'(i));
        end
        tick(); kp.evt_pop = 1'b0;
        chk("ovf_drain", kp.evt_count, 5'd0);
        chk("ovf_sticky", kp.overflow, 1'b1);
        kp.ovf_clr = 1'b1; tick(); kp.ovf_clr = 1'b0;
        chk("ovf_clr", kp.overflow, 1'b0);

        // Keys 10..14 flip in frame 24 at edges 572..576; pop coincides with the 5th push.
        run_to(480); keys = 16'h7E1F;
        run_to(504); keys = 16'h7C1F;
        run_to(575);
        chk("pp_pre_count", kp.evt_count, 5'd4);
        chk("pp_pre_head", kp.evt_data, 5'h0A);
        kp.evt_pop = 1'b1;
        run_to(576);
        chk("pp_count", kp.evt_count, 5'd4);
        chk("pp_ovf", kp.overflow, 1'b0);
        chk("pp_head", kp.evt_data, 5'h0B);
        run_to(577); chk("pp_order_c", kp.evt_data, 5'h0C);
        run_to(578); chk("pp_order_d", kp.evt_data, 5'h0D);
        run_to(579); chk("pp_order_e", kp.evt_data, 5'h0E);
        kp.scan_en = 1'b0;
        run_to(580); chk("pp_drain", kp.evt_count, 5'd0);
        run_to(581); kp.evt_pop = 1'b0;
        chk("pop_empty", kp.evt_count, 5'd0);

        // scan_en dropped in DRIVE r=1: frame 25 still runs and commits key 9's release.
        chk("noabort_row", kp.row, 4'hB);
        run_to(595);
        chk("noabort_data", kp.evt_data, 5'h19);
        chk("noabort_keys", kp.key_state, 16'h7C1F);
        run_to(600); chk("last_commit_row", kp.row, 4'hF);
        run_to(605);
        chk("idle_row", kp.row, 4'hF);
        chk("idle_count", kp.evt_count, 5'd1);

        // Reset during DRIVE r=2.
        kp.scan_en = 1'b1;
        run_to(610); chk("pre_rst_row", kp.row, 4'hB);
        HRESET = 1'b1;
        run_to(611); HRESET = 1'b0;
        chk("mid_rst_row", kp.row, 4'hF);
        chk("mid_rst_count", kp.evt_count, 5'd0);
        chk("mid_rst_keys", kp.key_state, 16'h0000);
        chk("mid_rst_valid", kp.evt_valid, 1'b0);
        run_to(612); chk("restart_r0", kp.row, 4'hE);

        // settle 0 behaves as 1; a change made during r2 only stretches r3.
        kp.settle_cycles = 16'd0;
        run_to(616); chk("settle0_row", kp.row, 4'hB);
        kp.settle_cycles = 16'd3;
        run_to(621); chk("settle3_row", kp.row, 4'h7);
        run_to(622); chk("settle3_commit", kp.row, 4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
